// File: rtl/cgra_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// cgra_cfg_sequencer
//
// Loads per-tile configuration words into a CGRA and then drives the global
// context counter that steps every tile through its kernel contexts.
//
// Flow: config words (tile, slot, payload, last) are accepted one at a time and
// forwarded to the addressed tile over a one-hot valid / per-tile ready write
// port. After the word flagged "last" the block is LOADED and accepts a start
// command carrying an iteration count; it then emits iters*KernelSize context
// cycles, pulses done_o, and returns to LOADED with the configuration retained.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cfg_valid_i / cfg_ready_o    config word handshake
//   cfg_tile_i, cfg_slot_i       target tile and context slot
//   cfg_data_i, cfg_last_i       config payload, final-word flag
//   start_valid_i / start_ready_o run request handshake
//   start_iters_i                iteration count for the run
//   tile_wr_valid_o              one-hot per-tile write valid
//   tile_wr_ready_i              per-tile write ready
//   tile_wr_addr_o/_data_o       shared write slot and payload
//   ctx_valid_o, ctx_o           tiles execute context ctx_o this cycle
//   done_o                       one-cycle pulse at run completion
//   busy_o                       issuing a word, running, or finishing
//   err_o                        sticky: a word addressed a non-existent tile
//
// All outputs come straight from flops; control outputs are registered from
// the next-state decode so they line up with the state they describe.
// -----------------------------------------------------------------------------
module cgra_cfg_sequencer #(
    parameter int CGRADim    = 16,
    parameter int KernelSize = 4,
    parameter int CfgWidth   = 43,
    parameter int IterWidth  = 16,
    parameter int TileIdW    = $clog2(CGRADim),
    parameter int SlotW      = $clog2(KernelSize)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [TileIdW-1:0]   cfg_tile_i,
    input  logic [SlotW-1:0]     cfg_slot_i,
    input  logic [CfgWidth-1:0]  cfg_data_i,
    input  logic                 cfg_last_i,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [IterWidth-1:0] start_iters_i,
    output logic [CGRADim-1:0]   tile_wr_valid_o,
    input  logic [CGRADim-1:0]   tile_wr_ready_i,
    output logic [SlotW-1:0]     tile_wr_addr_o,
    output logic [CfgWidth-1:0]  tile_wr_data_o,
    output logic                 ctx_valid_o,
    output logic [SlotW-1:0]     ctx_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_LOADED = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Tile count widened by one bit so an index equal to CGRADim is comparable.
    localparam logic [TileIdW:0]   TILE_LIMIT = (TileIdW+1)'(CGRADim);
    localparam logic [SlotW-1:0]   CTX_LAST   = SlotW'(KernelSize - 1);

    state_t                state_r,    state_n;
    logic [TileIdW-1:0]    tile_r,     tile_n;
    logic [SlotW-1:0]      slot_r,     slot_n;
    logic [CfgWidth-1:0]   data_r,     data_n;
    logic                  last_r,     last_n;
    logic [IterWidth-1:0]  iters_r,    iters_n;
    logic [IterWidth-1:0]  iter_cnt_r, iter_cnt_n;
    logic [SlotW-1:0]      ctx_r,      ctx_n;
    logic                  err_r,      err_n;

    logic                  cfg_ready_r;
    logic                  start_ready_r;
    logic [CGRADim-1:0]    wr_valid_r;
    logic                  ctx_valid_r;
    logic                  done_r;
    logic                  busy_r;

    logic                  tile_in_range_s;
    logic                  tile_ack_s;

    // One-hot decode of a tile index; indices outside the array decode to zero.
    function automatic logic [CGRADim-1:0] tile_onehot(input logic [TileIdW-1:0] t);
        logic [CGRADim-1:0] oh;
        oh = '0;
        for (int i = 0; i < CGRADim; i++) begin
            oh[i] = (t == TileIdW'(i));
        end
        return oh;
    endfunction

    // Range check of the incoming tile index and handshake of the held tile only.
    always_comb begin
        tile_in_range_s = ({1'b0, cfg_tile_i} < TILE_LIMIT);
        tile_ack_s      = |(tile_wr_ready_i & tile_onehot(tile_r));
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_n    = state_r;
        tile_n     = tile_r;
        slot_n     = slot_r;
        data_n     = data_r;
        last_n     = last_r;
        iters_n    = iters_r;
        iter_cnt_n = iter_cnt_r;
        ctx_n      = ctx_r;
        err_n      = err_r;

        case (state_r)
            ST_IDLE, ST_LOADED: begin
                // A config word wins over a simultaneous start in LOADED.
                if (cfg_valid_i) begin
                    if (tile_in_range_s) begin
                        tile_n  = cfg_tile_i;
                        slot_n  = cfg_slot_i;
                        data_n  = cfg_data_i;
                        last_n  = cfg_last_i;
                        state_n = ST_ISSUE;
                    end else begin
                        err_n   = 1'b1;
                    end
                end else if ((state_r == ST_LOADED) && start_valid_i) begin
                    if (start_iters_i == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        iters_n    = start_iters_i;
                        iter_cnt_n = '0;
                        ctx_n      = '0;
                        state_n    = ST_RUN;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            ST_ISSUE: begin
                if (tile_ack_s) begin
                    state_n = last_r ? ST_LOADED : ST_IDLE;
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_RUN: begin
                // ctx holds its final value when the run ends.
                if (ctx_r == CTX_LAST) begin
                    if (iter_cnt_r == (iters_r - IterWidth'(1))) begin
                        state_n = ST_DONE;
                    end else begin
                        ctx_n      = '0;
                        iter_cnt_n = iter_cnt_r + IterWidth'(1);
                    end
                end else begin
                    ctx_n = ctx_r + SlotW'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_LOADED;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, holding registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            tile_r        <= '0;
            slot_r        <= '0;
            data_r        <= '0;
            last_r        <= 1'b0;
            iters_r       <= '0;
            iter_cnt_r    <= '0;
            ctx_r         <= '0;
            err_r         <= 1'b0;
            cfg_ready_r   <= 1'b1;
            start_ready_r <= 1'b0;
            wr_valid_r    <= '0;
            ctx_valid_r   <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            tile_r        <= tile_n;
            slot_r        <= slot_n;
            data_r        <= data_n;
            last_r        <= last_n;
            iters_r       <= iters_n;
            iter_cnt_r    <= iter_cnt_n;
            ctx_r         <= ctx_n;
            err_r         <= err_n;
            cfg_ready_r   <= (state_n == ST_IDLE) || (state_n == ST_LOADED);
            start_ready_r <= (state_n == ST_LOADED);
            wr_valid_r    <= (state_n == ST_ISSUE) ? tile_onehot(tile_n) : '0;
            ctx_valid_r   <= (state_n == ST_RUN);
            done_r        <= (state_n == ST_DONE);
            busy_r        <= (state_n != ST_IDLE) && (state_n != ST_LOADED);
        end
    end

    assign cfg_ready_o     = cfg_ready_r;
    assign start_ready_o   = start_ready_r;
    assign tile_wr_valid_o = wr_valid_r;
    assign tile_wr_addr_o  = slot_r;
    assign tile_wr_data_o  = data_r;
    assign ctx_valid_o     = ctx_valid_r;
    assign ctx_o           = ctx_r;
    assign done_o          = done_r;
    assign busy_o          = busy_r;
    assign err_o           = err_r;

endmodule
